// File: rtl/sig_debounce.sv
// Synchronises and debounces a raw asynchronous level. A new level must hold for STABLE_CYCLES
// synchronised samples before it is accepted, and rejected transitions are counted as glitches.
module sig_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sig_raw,
    input  logic                glitch_clr,
    output logic                sig,
    output logic                settling,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int                CNT_W      = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

    typedef enum logic [1:0] {
        STABLE_LO,
        CHECK_HI,
        STABLE_HI,
        CHECK_LO
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sig_q, sig_d;
    logic                   glitch;
    logic [GLITCH_W-1:0]    glitch_q;

    // Only the last synchroniser stage is allowed to feed logic.
    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_raw};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        glitch  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = CHECK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    sig_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = CHECK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    glitch  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    sig_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                sig_d   = 1'b0;
            end
        endcase
    end

    // A clear in the same cycle as a glitch wins; that glitch is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            glitch_q <= '0;
        end else if (glitch_clr) begin
            glitch_q <= '0;
        end else if (glitch && (glitch_q != GLITCH_MAX)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign sig        = sig_q;
    assign settling   = (state_q == CHECK_HI) || (state_q == CHECK_LO);
    assign glitch_cnt = glitch_q;

endmodule

// File: doc/sig_debounce.md
# sig_debounce

Input conditioning stage placed directly upstream of the rising-edge pulse generator. It synchronises a raw, asynchronous, possibly bouncing level `sig_raw` into the `clk` domain. It drives the generator's `sig` input only after the new level has been stable for a programmable number of cycles. Rejected transitions, which are glitches, are counted for debug.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop depth; legal range 2..4.
- `STABLE_CYCLES`, default 4: consecutive synchronised samples required to accept a new level; legal range 2..65535.
- `GLITCH_W`, default 8: width of the glitch counter.
- `clk`  in  1  single clock; all state on the rising edge.
- `rstn`  in  1  asynchronous active-low reset, asserted async, released synchronously by the top level.
- `sig_raw`  in  1  raw asynchronous level, no timing relation to `clk`.
- `glitch_clr`  in  1  synchronous clear of `glitch_cnt`.
- `sig`  out  1  debounced level, registered; connects to the pulse generator's `sig`.
- `settling`  out  1  high while a candidate transition is being qualified.
- `glitch_cnt`  out  GLITCH_W  count of rejected transitions, saturating.

## Operation
- Synchroniser: `SYNC_STAGES` flops in series, all reset to 0. Let `s` denote the last stage output. Only `s` feeds logic.
- FSM has four states, reset state STABLE_LO:
  - STABLE_LO (`sig`=0): if `s`=1, go to CHECK_HI with `cnt`=1.
  - CHECK_HI (`sig`=0):
    - if `s`=0, go to STABLE_LO and count a glitch;
    - else if `cnt`=STABLE_CYCLES-1, go to STABLE_HI and set `sig`=1;
    - else `cnt`++.
  - STABLE_HI (`sig`=1): if `s`=0, go to CHECK_LO with `cnt`=1.
  - CHECK_LO (`sig`=1): mirror of CHECK_HI. Return to STABLE_HI on `s`=1 with a glitch counted. Go to STABLE_LO with `sig`=0 at `cnt`=STABLE_CYCLES-1.
- `cnt` width is clog2(STABLE_CYCLES). It never exceeds STABLE_CYCLES-1, so there is no wrap.
- `settling` = state is CHECK_HI or CHECK_LO. It is decoded from the state register only and is glitch-free.
- `sig` is a flop. It changes only on the STABLE_* entry transitions, so it carries no combinational path from `sig_raw`.
- `glitch_cnt`:
  - +1 on each CHECK→STABLE return to the same level;
  - holds at 2^GLITCH_W-1;
  - `glitch_clr` forces it to 0.
  - If a clear and a glitch occur in the same cycle, the clear wins: result 0, and that glitch is not counted.
- Reset at any time, including mid-CHECK, forces:
  - all synchroniser flops to 0;
  - state STABLE_LO, `cnt`=0;
  - `sig`=0, `settling`=0, `glitch_cnt`=0.
- If `sig_raw` is high across reset release, it is qualified normally. `sig` then rises once, and downstream sees one pulse. This is intended.

## Timing
- Reset values: `sig`=0, `settling`=0, `glitch_cnt`=0.
- Edge 0 is the first clock edge that samples a new stable `sig_raw` level. After that:
  - `s` shows the new level after edge SYNC_STAGES-1;
  - `settling` rises after edge SYNC_STAGES;
  - `sig` and `settling` change together after edge SYNC_STAGES+STABLE_CYCLES-1.
- Total latency is SYNC_STAGES+STABLE_CYCLES edges, which is 6 with the defaults.
- `settling` is high for exactly STABLE_CYCLES-1 cycles per accepted transition.
- A pulse on `s` shorter than STABLE_CYCLES samples never reaches `sig`.
- A pulse of exactly STABLE_CYCLES samples is accepted.
- Minimum `sig` high/low time is STABLE_CYCLES cycles, so downstream pulses are spaced at least 2·STABLE_CYCLES cycles apart.
- Sub-cycle `sig_raw` pulses may be missed entirely by the synchroniser. This is acceptable: nothing is counted if `s` never changes.

## Test plan
All cases use defaults and a 10 ns clock.
- Reset: hold `rstn`=0 while toggling `sig_raw` → `sig`=0, `settling`=0, `glitch_cnt`=0 throughout. After release with `sig_raw`=1 → `sig`=1 after the 6th edge.
- Clean rise: `sig_raw` 0→1 before edge 0, held high → `settling` high after edges 2..4 (3 cycles), `sig`=1 after edge 5. Clean fall has identical timing, with `sig`=0 after edge 5.
- Bounce rejection:
  - `sig_raw` high for 3 cycles, then low → `sig` stays 0 and `glitch_cnt`=1.
  - Held high exactly 4 cycles → `sig` pulses high for ≥4 cycles and `glitch_cnt` is unchanged.
- Saturation: 300 three-cycle glitches → `glitch_cnt`=255 and holds. Then `glitch_clr`=1 for one cycle → 0.
- Simultaneous clear and glitch: assert `glitch_clr` on the cycle CHECK_HI returns to STABLE_LO → `glitch_cnt`=0 the next cycle, not 1.
- Reset mid-operation: assert `rstn`=0 while in CHECK_LO (`sig`=1, `settling`=1) → all outputs 0 immediately, without waiting for a clock edge. With `sig_raw`=1 held, `sig` re-rises 6 edges after release.
